sram_be_arbiter: RTL

Two-port round-robin arbiter and init sequencer for a single-port, byte-enabled synchronous SRAM wrapper (256 x 64 by default, 1-cycle read latency). It shares the one macro port between two requesters using a valid/ready request channel and a fixed-latency read response. When configured in, it first zero-fills the whole array after reset. It sits between the cache/scratchpad control logic and the SRAM wrapper; its memory-side outputs use active-high chip-select and write-enable.

---
 rtl/sram_be_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/sram_be_arbiter.sv
// rtl/sram_be_arbiter.sv - two-port round-robin arbiter and zero-fill init sequencer for a byte-enabled SRAM (optional init: SRAM_ARB_INIT_EN)
module sram_be_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 64,
  parameter int BE_W   = DATA_W / 8
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RI,
  input  logic [1:0]            ReqValid_SI,
  output logic [1:0]            ReqReady_SO,
  input  logic [1:0]            ReqWe_SI,
  input  logic [2*ADDR_W-1:0]   ReqAddr_DI,
  input  logic [2*BE_W-1:0]     ReqBe_SI,
  input  logic [2*DATA_W-1:0]   ReqWData_DI,
  output logic [1:0]            RspValid_SO,
  output logic [DATA_W-1:0]     RspRData_DO,
  output logic                  InitDone_SO,
  output logic                  MemCSel_SO,
  output logic                  MemWrEn_SO,
  output logic [BE_W-1:0]       MemBEn_SO,
  output logic [ADDR_W-1:0]     MemAddr_DO,
  output logic [DATA_W-1:0]     MemWrData_DO,
  input  logic [DATA_W-1:0]     MemRdData_DI
);

  logic              run;
  logic              init_wr;
  logic [ADDR_W-1:0] init_addr;
  logic              ptr_q;
  logic              rd_pend_q;
  logic              rd_port_q;
  logic [1:0]        gnt;
  logic              gnt_any;
  logic              gnt_id;

`ifdef SRAM_ARB_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t            state_q;
  logic [ADDR_W-1:0] init_cnt_q;

  // Zero-fill sweep: one write per cycle, leave INIT after the last address
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else if (state_q == ST_INIT) begin
      init_cnt_q <= init_cnt_q + 1'b1;
      if (init_cnt_q == {ADDR_W{1'b1}}) state_q <= ST_RUN;
    end
  end

  assign run       = (state_q == ST_RUN);
  assign init_wr   = (state_q == ST_INIT) && !Rst_RI;
  assign init_addr = init_cnt_q;
`else
  assign run       = 1'b1;
  assign init_wr   = 1'b0;
  assign init_addr = '0;
`endif

  assign InitDone_SO = run;

  // Grant: a lone requester wins, contention resolved by the priority pointer
  always_comb begin
    gnt = 2'b00;
    if (run && !Rst_RI) begin
      case (ReqValid_SI)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

  assign gnt_any     = |gnt;
  assign gnt_id      = gnt[1];
  assign ReqReady_SO = gnt;

  // Macro port drive: init writes, else the granted request, else idle zeros
  always_comb begin
    MemCSel_SO   = 1'b0;
    MemWrEn_SO   = 1'b0;
    MemBEn_SO    = '0;
    MemAddr_DO   = '0;
    MemWrData_DO = '0;
    if (init_wr) begin
      MemCSel_SO   = 1'b1;
      MemWrEn_SO   = 1'b1;
      MemBEn_SO    = '1;
      MemAddr_DO   = init_addr;
    end else if (gnt_any) begin
      MemCSel_SO   = 1'b1;
      MemWrEn_SO   = ReqWe_SI[gnt_id];
      MemBEn_SO    = gnt_id ? ReqBe_SI[BE_W +: BE_W]       : ReqBe_SI[0 +: BE_W];
      MemAddr_DO   = gnt_id ? ReqAddr_DI[ADDR_W +: ADDR_W] : ReqAddr_DI[0 +: ADDR_W];
      MemWrData_DO = gnt_id ? ReqWData_DI[DATA_W +: DATA_W] : ReqWData_DI[0 +: DATA_W];
    end
  end

  // Pointer flips to the other requester after every grant; remember read owner
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      ptr_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_port_q <= 1'b0;
    end else begin
      rd_pend_q <= gnt_any && !ReqWe_SI[gnt_id];
      if (gnt_any) begin
        ptr_q     <= ~gnt_id;
        rd_port_q <= gnt_id;
      end
    end
  end

  // Read data flows straight from the macro, steered to the owning requester
  always_comb begin
    RspValid_SO = 2'b00;
    RspRData_DO = '0;
    if (rd_pend_q) begin
      RspValid_SO = rd_port_q ? 2'b10 : 2'b01;
      RspRData_DO = MemRdData_DI;
    end
  end

endmodule
